// File: rtl/mu_event_detector.sv
// Debounced hysteresis event detector for pooled mu samples with an event queue.
// Ports: clk/rst, mu_in+mu_valid, thr_hi/thr_lo, evt_* valid/ready queue head,
// active, overflow. Optional timestamping via macro MU_EVENT_TIMESTAMP_EN
// (adds evt_ts port, ts counter and per-entry ts storage).
module mu_event_detector #(
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mu_in,
  input  logic        mu_valid,
  input  logic [7:0]  thr_hi,
  input  logic [7:0]  thr_lo,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        evt_rise,
  output logic [7:0]  evt_level,
`ifdef MU_EVENT_TIMESTAMP_EN
  output logic [15:0] evt_ts,
`endif
  output logic        active,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND_HI,
    S_ACTIVE,
    S_PEND_LO
  } state_e;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef MU_EVENT_TIMESTAMP_EN
  localparam int EW = 25;
`else
  localparam int EW = 9;
`endif

  localparam logic [3:0]    DB      = 4'(DEBOUNCE);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cnt_inc;
  logic          hi_hit, lo_hit;
  logic          push, push_rise;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic          pop, full, wr_en, drop;
  logic [EW-1:0] entry_w, head;

`ifdef MU_EVENT_TIMESTAMP_EN
  logic [15:0]   ts_q;
`endif

  assign hi_hit  = mu_in >= thr_hi;
  assign lo_hit  = mu_in <= thr_lo;
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_rise = 1'b0;
    if (mu_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (hi_hit) begin
            if (DB == 4'd1) begin
              state_d   = S_ACTIVE;
              cnt_d     = 4'd0;
              push      = 1'b1;
              push_rise = 1'b1;
            end else begin
              state_d = S_PEND_HI;
              cnt_d   = 4'd1;
            end
          end
        end
        S_PEND_HI: begin
          if (!hi_hit) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_inc == DB) begin
            state_d   = S_ACTIVE;
            cnt_d     = 4'd0;
            push      = 1'b1;
            push_rise = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_ACTIVE: begin
          if (lo_hit) begin
            if (DB == 4'd1) begin
              state_d = S_IDLE;
              cnt_d   = 4'd0;
              push    = 1'b1;
            end else begin
              state_d = S_PEND_LO;
              cnt_d   = 4'd1;
            end
          end
        end
        S_PEND_LO: begin
          if (!lo_hit) begin
            state_d = S_ACTIVE;
            cnt_d   = 4'd0;
          end else if (cnt_inc == DB) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            push    = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

`ifdef MU_EVENT_TIMESTAMP_EN
  assign entry_w = {push_rise, mu_in, ts_q};
`else
  assign entry_w = {push_rise, mu_in};
`endif

  assign evt_valid = count_q != '0;
  assign pop       = evt_valid & evt_ready;
  assign full      = count_q == DEPTH_C;
  // A pop frees the slot in the same edge, so a full queue still accepts.
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !wr_en) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (drop)  ovf_q    <= 1'b1;
    end
  end

`ifdef MU_EVENT_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= 16'd0;
    end else if (mu_valid) begin
      ts_q <= ts_q + 16'd1;
    end
  end
`endif

  // Storage needs no reset: head outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= entry_w;
  end

  assign head      = mem_q[rd_ptr_q];
  assign evt_rise  = evt_valid & head[EW-1];
  assign evt_level = evt_valid ? head[EW-2 -: 8] : 8'd0;
`ifdef MU_EVENT_TIMESTAMP_EN
  assign evt_ts    = evt_valid ? head[15:0] : 16'd0;
`endif

  assign active   = (state_q == S_ACTIVE) || (state_q == S_PEND_LO);
  assign overflow = ovf_q;

endmodule

// File: doc/mu_event_detector.md
MU_EVENT_DETECTOR -- requirements
Module: mu_event_detector

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive qualifying samples needed to change state, legal 1..15.
REQ-002 Parameter FIFO_DEPTH, default 4: event queue entries, power of two, 2..16.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mu_in  input  8  pooled sample from the upstream pooling stage.
REQ-006 mu_valid  input  1  mu_in is a new sample this cycle.
REQ-007 thr_hi  input  8  rise threshold, unsigned.
REQ-008 thr_lo  input  8  fall threshold, unsigned; thr_lo < thr_hi required, otherwise behaviour is undefined.
REQ-009 evt_valid  output  1  queue head is valid.
REQ-010 evt_ready  input  1  consumer accepts head.
REQ-011 evt_rise  output  1  head type: 1 = rise, 0 = fall.
REQ-012 evt_level  output  8  mu_in value of the sample that completed the debounce.
REQ-013 evt_ts  output  16  sample timestamp; present only with the macro in REQ-030.
REQ-014 active  output  1  high in ACTIVE and PEND_LO.
REQ-015 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-016 FSM states: IDLE, PEND_HI, ACTIVE, PEND_LO; state and counters change only on cycles with mu_valid=1.
REQ-017 IDLE: mu_in >= thr_hi -> PEND_HI with cnt=1; when DEBOUNCE=1, go directly to ACTIVE and emit a rise event.
REQ-018 PEND_HI: mu_in >= thr_hi -> cnt+1; when cnt+1 = DEBOUNCE -> ACTIVE and emit a rise event; mu_in < thr_hi -> IDLE with cnt=0.
REQ-019 ACTIVE: mu_in <= thr_lo -> PEND_LO with cnt=1; DEBOUNCE=1 -> IDLE directly and emit a fall event.
REQ-020 PEND_LO: mu_in <= thr_lo -> cnt+1; when cnt+1 = DEBOUNCE -> IDLE and emit a fall event; mu_in > thr_lo -> ACTIVE with cnt=0.
REQ-021 Hysteresis: samples strictly between thr_lo and thr_hi never start a pending count; a pending count they interrupt aborts back to the stable state.
REQ-022 Emit: push {rise, level[, ts]} into the FIFO in the same cycle as the transition; evt_valid rises the next cycle when the FIFO was empty (1-cycle latency).
REQ-023 Handshake: head pops on evt_valid & evt_ready; head fields hold stable while evt_valid=1 and evt_ready=0.
REQ-024 Full FIFO, push without pop: drop the new event, set overflow, leave the FIFO unchanged.
REQ-025 Full FIFO, push and pop in the same cycle: the pop occurs and the push is accepted; no overflow.
REQ-026 Empty FIFO, push and pop in the same cycle: impossible, since evt_valid=0; the push is stored.
REQ-027 Pointers wrap modulo FIFO_DEPTH; a count register of width clog2(FIFO_DEPTH)+1 distinguishes full from empty.
REQ-028 Threshold changes take effect on the next mu_valid sample; the current state and cnt are kept.

Reset
REQ-029 rst=1 at a clock edge forces state=IDLE, cnt=0, FIFO empty, evt_valid=0, evt_rise=0, evt_level=0, evt_ts=0, active=0, overflow=0, ts counter=0; reset mid-pending or mid-handshake discards all queued events with no pop.

Configuration
REQ-030 Macro MU_EVENT_TIMESTAMP_EN defined: 16-bit ts counter increments by 1 (wrapping) on every mu_valid; each event records the ts of its completing sample; the evt_ts port exists.
REQ-031 Macro MU_EVENT_TIMESTAMP_EN undefined: the evt_ts port, counter and FIFO ts storage are absent; all other behaviour is identical.

Verification
REQ-032 DEBOUNCE=4, thr_hi=100, thr_lo=50, evt_ready=1, mu_in=120 for 4 valid samples -> one rise event with evt_level=120 one cycle after the 4th sample; active=1.
REQ-033 From ACTIVE, mu_in sequence 40,40,80,40,40,40,40 -> no event before the 80 (count aborts at 80); fall event with evt_level=40 after the 4th consecutive 40; active=0.
REQ-034 evt_ready=0, 5 rise/fall alternations with FIFO_DEPTH=4 -> 4 events held in order, 5th dropped, overflow=1; overflow stays 1 after the queue drains.
REQ-035 FIFO full, evt_ready=1 in the same cycle as a new event -> oldest event popped, new one stored, overflow stays 0, count stays 4.
REQ-036 rst asserted in PEND_HI with cnt=3 and 2 queued events -> next cycle evt_valid=0 and state IDLE; a further 3 samples >=thr_hi produce no event.
REQ-037 MU_EVENT_TIMESTAMP_EN defined, 10 valid samples below thr_lo then 4 at 200 -> rise event with evt_ts=13.
